// File: rtl/vedic_mac_pkg.sv
// Shared widths and FSM state encoding for the Vedic MAC accumulator.
// Imported by vedic_sat_add and vedic_mac_accum.
package vedic_mac_pkg;

    localparam int ACC_W  = 16;
    localparam int PROD_W = 8;
    localparam int CNT_W  = 10;

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_LO  = 2'd1,
        S_HI  = 2'd2
    } mac_state_t;

endpackage

// File: rtl/vedic_sat_add.sv
// 16-bit + 8-bit unsigned adder with overflow flag.
// Ports: a (accumulator), b (product), sum, ovf (carry out of bit 15).
// VEDIC_MAC_SAT_EN: defined -> sum clamps at 16'hFFFF, else wraps.
module vedic_sat_add
    import vedic_mac_pkg::*;
(
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W:0] full;

    assign full = {1'b0, a} + {{(ACC_W-PROD_W+1){1'b0}}, b};
    assign ovf  = full[ACC_W];

`ifdef VEDIC_MAC_SAT_EN
    assign sum = ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/vedic_mac_accum.sv
// Sums N_TERMS multiplier products, then streams the 16-bit sum as
// two bytes (low first). Ports: clk, rst (async high), in_valid/
// in_ready/in_prod, clear, out_valid/out_ready/out_byte/out_last,
// term_cnt, sat. VEDIC_MAC_SAT_EN selects saturating accumulation.
module vedic_mac_accum
    import vedic_mac_pkg::*;
#(
    parameter int N_TERMS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic [CNT_W-1:0]  term_cnt,
    output logic              sat
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS);

    mac_state_t        state;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  sum;
    logic              ovf;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              accept;
    logic              done;

    vedic_sat_add u_add (
        .a   (acc),
        .b   (in_prod),
        .sum (sum),
        .ovf (ovf)
    );

    assign cnt_nxt = term_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign accept  = !clear && in_valid && (state == S_ACC);
    // Window ends after the high byte is taken.
    assign done    = !clear && out_ready && (state == S_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_ACC;
            acc      <= '0;
            term_cnt <= '0;
        end else if (clear) begin
            state    <= S_ACC;
            acc      <= '0;
            term_cnt <= '0;
        end else begin
            unique case (state)
                S_ACC: begin
                    if (in_valid) begin
                        acc      <= sum;
                        term_cnt <= cnt_nxt;
                        if (cnt_nxt == LAST)
                            state <= S_LO;
                    end
                end
                S_LO: begin
                    if (out_ready)
                        state <= S_HI;
                end
                S_HI: begin
                    if (out_ready) begin
                        state    <= S_ACC;
                        acc      <= '0;
                        term_cnt <= '0;
                    end
                end
                default: state <= S_ACC;
            endcase
        end
    end

`ifdef VEDIC_MAC_SAT_EN
    logic sat_q;

    // Sticky for the whole window, including both output bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_q <= 1'b0;
        else if (clear || done)
            sat_q <= 1'b0;
        else if (accept && ovf)
            sat_q <= 1'b1;
    end

    assign sat = sat_q;
`else
    logic unused_ovf;
    logic unused_done;

    assign unused_ovf  = ovf;
    assign unused_done = done ^ accept;
    assign sat         = 1'b0;
`endif

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_byte  = 8'h00;
        out_last  = 1'b0;
        unique case (state)
            S_ACC: in_ready = 1'b1;
            S_LO: begin
                out_valid = 1'b1;
                out_byte  = acc[7:0];
            end
            S_HI: begin
                out_valid = 1'b1;
                out_byte  = acc[15:8];
                out_last  = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_vedic_mac_accum.sv
// Randomized self-checking bench for vedic_mac_accum.
// Three instances: N_TERMS = 4, 1 and 300.
module tb_vedic_mac_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] in_valid, in_ready, clear;
    logic [2:0] out_valid, out_ready, out_last, sat;
    logic [7:0] in_prod  [3];
    logic [7:0] out_byte [3];
    logic [9:0] term_cnt [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vedic_mac_accum #(.N_TERMS(4)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .in_prod(in_prod[0]),
        .clear(clear[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_byte(out_byte[0]),
        .out_last(out_last[0]), .term_cnt(term_cnt[0]),
        .sat(sat[0])
    );

    vedic_mac_accum #(.N_TERMS(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .in_prod(in_prod[1]),
        .clear(clear[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_byte(out_byte[1]),
        .out_last(out_last[1]), .term_cnt(term_cnt[1]),
        .sat(sat[1])
    );

    vedic_mac_accum #(.N_TERMS(300)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .in_prod(in_prod[2]),
        .clear(clear[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_byte(out_byte[2]),
        .out_last(out_last[2]), .term_cnt(term_cnt[2]),
        .sat(sat[2])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer sum, then wrap or clamp.
    function automatic logic [15:0] model_res(input int total);
`ifdef VEDIC_MAC_SAT_EN
        return (total > 65535) ? 16'hFFFF : total[15:0];
`else
        return total[15:0];
`endif
    endfunction

    function automatic logic model_sat(input int total);
`ifdef VEDIC_MAC_SAT_EN
        return total > 65535;
`else
        return 1'b0 & total[0];
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the accept.
    task automatic send(input int d, input logic [7:0] p);
        int n = 0;
        in_valid[d] = 1'b1;
        in_prod[d]  = p;
        while (!in_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("send_tmo", n >= 100, 0);
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    task automatic recv(input int d, input int hold,
                        output logic [15:0] r, output logic s);
        r = '0;
        s = 1'b0;
        for (int b = 0; b < 2; b++) begin
            int n = 0;
            logic [7:0] first;
            while (!out_valid[d] && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("recv_tmo", n >= 100, 0);
            if (b == 0) s = sat[d];
            first = out_byte[d];
            chk("recv_last", out_last[d], b);
            chk("recv_rdy", in_ready[d], 0);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_byte", out_byte[d], first);
                chk("hold_valid", out_valid[d], 1);
            end
            out_ready[d] = 1'b1;
            @(negedge clk);
            out_ready[d] = 1'b0;
            r[b*8 +: 8] = first;
        end
    endtask

    task automatic window(input int d, input int nt, input int gaps,
                          input int hold, input bit rnd, input int val,
                          input string tag);
        int total = 0;
        logic [15:0] r;
        logic s;
        for (int i = 0; i < nt; i++) begin
            int p = rnd ? int'($urandom_range(0, 225)) : val;
            if (gaps != 0)
                repeat ($urandom_range(0, gaps)) @(negedge clk);
            total += p;
            send(d, p[7:0]);
        end
        recv(d, hold, r, s);
        chk({tag, "_res"}, r, model_res(total));
        chk({tag, "_sat"}, s, model_sat(total));
        chk({tag, "_cnt"}, term_cnt[d], 0);
        chk({tag, "_rdy"}, in_ready[d], 1);
    endtask

    initial begin
        logic [7:0] basic [4];
        logic [15:0] r;
        logic s;
        basic = '{8'd6, 8'd20, 8'd225, 8'd0};
        in_valid  = '0;
        clear     = '0;
        out_ready = '0;
        for (int d = 0; d < 3; d++) in_prod[d] = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_rdy", in_ready[d], 1);
            chk("rst_ov", out_valid[d], 0);
            chk("rst_byte", out_byte[d], 0);
            chk("rst_last", out_last[d], 0);
            chk("rst_cnt", term_cnt[d], 0);
            chk("rst_sat", sat[d], 0);
        end

        // Basic window, back-to-back, out_ready high.
        for (int i = 0; i < 4; i++) send(0, basic[i]);
        chk("bas_ov", out_valid[0], 1);
        chk("bas_lo", out_byte[0], 8'hFB);
        chk("bas_lo_last", out_last[0], 0);
        chk("bas_cnt", term_cnt[0], 4);
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bas_hi", out_byte[0], 8'h00);
        chk("bas_hi_last", out_last[0], 1);
        @(negedge clk);
        out_ready[0] = 1'b0;
        chk("bas_rdy", in_ready[0], 1);
        chk("bas_ov0", out_valid[0], 0);
        chk("bas_byte0", out_byte[0], 0);

        // Backpressure on the low byte.
        for (int i = 0; i < 4; i++) send(0, basic[i]);
        recv(0, 3, r, s);
        chk("bp_res", r, 16'h00FB);

        // Clear wins over a simultaneous product.
        send(0, 225);
        send(0, 225);
        in_valid[0] = 1'b1;
        in_prod[0]  = 8'd77;
        clear[0]    = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        clear[0]    = 1'b0;
        chk("clr_cnt", term_cnt[0], 0);
        chk("clr_rdy", in_ready[0], 1);
        for (int i = 1; i <= 4; i++) send(0, i[7:0]);
        recv(0, 0, r, s);
        chk("clr_res", r, 16'h000A);

        // Reset while the high byte is pending.
        for (int i = 0; i < 4; i++) send(0, 8'd50);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        chk("rhi_last", out_last[0], 1);
        rst = 1'b1;
        #1;
        chk("rhi_ov", out_valid[0], 0);
        chk("rhi_byte", out_byte[0], 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rhi_nosend", out_valid[0], 0);
        chk("rhi_cnt", term_cnt[0], 0);
        for (int i = 0; i < 4; i++) send(0, 8'd9);
        recv(0, 0, r, s);
        chk("rhi_res", r, 16'h0024);

        // N_TERMS = 1 with idle gaps.
        repeat (2) @(negedge clk);
        chk("n1_idle", in_ready[1], 1);
        send(1, 225);
        chk("n1_ov", out_valid[1], 1);
        recv(1, 0, r, s);
        chk("n1_res_a", r, 16'h00E1);
        repeat (3) @(negedge clk);
        chk("n1_idle2", in_ready[1], 1);
        send(1, 100);
        recv(1, 0, r, s);
        chk("n1_res_b", r, 16'h0064);

        // Overflow window: 300 x 225 = 67500.
        window(2, 300, 0, 0, 0, 225, "ovf");

        // Randomized windows against the model.
        for (int w = 0; w < 12; w++)
            window(0, 4, 2, $urandom_range(0, 2), 1, 0, "rnd4");
        for (int w = 0; w < 8; w++)
            window(1, 1, 3, $urandom_range(0, 2), 1, 0, "rnd1");
        window(2, 300, 0, 1, 1, 0, "rnd300");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/vedic_mac_accum.md
# vedic_mac_accum

Downstream consumer of the 4x4 Vedic multiplier's 8-bit products. Accepts one product per valid/ready handshake, sums a fixed window of N_TERMS products into a 16-bit accumulator, then streams the result out over an 8-bit port as two bytes (low byte first). It fits the TinyTapeout 8-bit output pin budget and turns the multiplier into a dot-product / MAC engine.

## Interface
- N_TERMS, 4, products per accumulation window; legal range 1..1023
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  product present on in_prod
- in_ready  out  1  block can accept a product this cycle
- in_prod  in  8  unsigned product from the multiplier (0..225)
- clear  in  1  synchronous abort of the current window
- out_valid  out  1  out_byte holds a result byte
- out_ready  in  1  consumer takes out_byte this cycle
- out_byte  out  8  result byte
- out_last  out  1  high with the high (final) byte
- term_cnt  out  10  products accepted in the current window
- sat  out  1  current/last result saturated (see Configuration)

## Operation
- FSM states: S_ACC, S_LO, S_HI. Reset state is S_ACC.
- S_ACC:
  - in_ready = 1.
  - An accept happens when in_valid && in_ready. On accept: acc <= acc + in_prod and term_cnt++.
  - If the accept brings term_cnt to N_TERMS, the FSM goes to S_LO with the final sum held in acc.
- S_LO:
  - in_ready = 0, out_valid = 1, out_byte = acc[7:0], out_last = 0.
  - On out_ready the FSM goes to S_HI.
- S_HI:
  - in_ready = 0, out_valid = 1, out_byte = acc[15:8], out_last = 1.
  - On out_ready the FSM goes to S_ACC with acc = 0, term_cnt = 0 and sat = 0.
- When out_valid = 0, out_byte = 0 and out_last = 0.
- clear has the highest priority of any synchronous event. In any state, clear = 1 means:
  - next state is S_ACC, acc = 0, term_cnt = 0, sat = 0;
  - no input accept and no output transfer happen in that cycle.
- Width rules: the accumulator is 16-bit unsigned and in_prod is zero-extended. Overflow handling is set by the macro below.
- Inputs offered while in_ready = 0 are not consumed. The producer must hold them until they are accepted.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state S_ACC, acc = 0, term_cnt = 0, sat = 0;
  - out_valid = 0, out_byte = 0, out_last = 0, in_ready = 1.
- in_ready, out_valid, out_byte and out_last decode combinationally from registered state and acc. There is no input-to-output combinational path.
- Latency: final product accepted at edge t means out_valid = 1 (low byte) in the cycle after t.
- Throughput: N_TERMS + 2 cycles per window with no backpressure.
- Under backpressure, out_byte and out_last stay stable while out_valid && !out_ready.
- N_TERMS = 1: every accept goes straight to S_LO.
- Reset during S_LO/S_HI discards the pending result. No byte is re-sent after reset.

## Configuration
- VEDIC_MAC_SAT_EN defined:
  - the add saturates at 16'hFFFF;
  - sat sets when any add in the window would exceed 65535;
  - sat holds through S_LO/S_HI and clears when the window restarts or on clear.
- VEDIC_MAC_SAT_EN undefined:
  - the add wraps modulo 2^16;
  - sat is tied to 0.
- Overflow is only reachable when N_TERMS ≥ 292.

## Structure
- Package vedic_mac_pkg holds:
  - the state enum (S_ACC, S_LO, S_HI);
  - ACC_W = 16, PROD_W = 8, CNT_W = 10.
- One sub-module: vedic_sat_add. It is a 16-bit + 8-bit adder with the sum output and an overflow flag. Saturation is selected by VEDIC_MAC_SAT_EN.
- The FSM, counter and output mux live in vedic_mac_accum.

## Test plan
- Basic window: N_TERMS = 4, out_ready = 1, products 6, 20, 225, 0 back-to-back -> out_byte 0xFB (out_last = 0) then 0x00 (out_last = 1); in_ready returns to 1 the following cycle.
- Backpressure: same products, out_ready = 0 for 3 cycles in S_LO -> 0xFB held stable with out_valid = 1 and in_ready = 0; then both bytes transfer in order.
- Clear mid-window: accept 225, 225, assert clear together with in_valid on a third product -> that product is not accepted and term_cnt = 0; then 1, 2, 3, 4 -> result 0x000A.
- Saturation: N_TERMS = 300, 300 products of 225 (sum 67500):
  - with VEDIC_MAC_SAT_EN -> bytes 0xFF, 0xFF and sat = 1;
  - without it -> bytes 0xAC, 0x07 and sat = 0.
- Reset mid-output: assert rst while in S_HI -> out_valid = 0 immediately; after release, a fresh window of 9, 9, 9, 9 yields 0x24, 0x00.
- N_TERMS = 1 with input gaps: products 225 and 100, separated by idle cycles -> two results, 0xE1/0x00 and 0x64/0x00; in_ready = 0 only during each result's two output cycles.
